id_ex_operand_stage: RTL



---
 rtl/id_ex_operand_stage_pkg.sv | 36 +++
 rtl/id_ex_operand_stage_fwd_mux.sv | 34 +++
 rtl/id_ex_operand_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, register-index constants and the ID/EX payload record for the operand stage.
package id_ex_operand_stage_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;

   typedef logic [DATA_WIDTH-1:0]     data_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   localparam reg_addr_t REG_X0 = '0;

   // Everything decode hands over; register data is kept raw and forwarded at the EX output.
   typedef struct packed {
      reg_addr_t rs1_addr;
      logic      rs1_used;
      data_t     rs1_data;
      reg_addr_t rs2_addr;
      logic      rs2_used;
      data_t     rs2_data;
      data_t     imm;
      data_t     pc;
      logic      use_pc;
      logic      use_imm;
      logic      sub;
      reg_addr_t rd_addr;
      logic      rd_we;
      logic      is_load;
   } id_ex_t;

   // A live read of src matches a pending write of dst; x0 never matches.
   function automatic logic src_hit(input reg_addr_t src, input logic used,
                                    input reg_addr_t dst, input logic we);
      return used & we & (src != REG_X0) & (src == dst);
   endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM (non-load) beats MEM/WB, which beats the stored register value.
module iex_fwd_mux
   import id_ex_operand_stage_pkg::*;
(
   input  reg_addr_t idx_i,
   input  logic      used_i,
   input  data_t     reg_data_i,
   input  reg_addr_t exm_rd_addr_i,
   input  logic      exm_rd_we_i,
   input  logic      exm_is_load_i,
   input  data_t     exm_data_i,
   input  reg_addr_t mwb_rd_addr_i,
   input  logic      mwb_rd_we_i,
   input  data_t     mwb_data_i,
   output data_t     data_o
);

   logic exm_hit;
   logic mwb_hit;

   // A load in EX/MEM has no data yet; the load-use bubble covers that case.
   assign exm_hit = src_hit(idx_i, used_i, exm_rd_addr_i, exm_rd_we_i & ~exm_is_load_i);
   assign mwb_hit = src_hit(idx_i, used_i, mwb_rd_addr_i, mwb_rd_we_i);

   always_comb begin
      data_o = reg_data_i;
      if (exm_hit) begin
         data_o = exm_data_i;
      end else if (mwb_hit) begin
         data_o = mwb_data_i;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with load-use hazard detection, flush, and forwarded adder operand selection.
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic [DATA_WIDTH-1:0]     id_rs1_data,
   input  logic [DATA_WIDTH-1:0]     id_rs2_data,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic [DATA_WIDTH-1:0]     id_pc,
   input  logic                      id_use_pc,
   input  logic                      id_use_imm,
   input  logic                      id_sub,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
   input  logic                      id_rd_we,
   input  logic                      id_is_load,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr,
   input  logic                      exm_rd_we,
   input  logic                      exm_is_load,
   input  logic [DATA_WIDTH-1:0]     exm_data,
   input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_addr,
   input  logic                      mwb_rd_we,
   input  logic [DATA_WIDTH-1:0]     mwb_data,
   output logic                      stall_id,
   output logic                      ex_valid,
   output logic [DATA_WIDTH-1:0]     adder_data_in_1,
   output logic [DATA_WIDTH-1:0]     adder_data_in_2,
   output logic                      sub,
   output logic [DATA_WIDTH-1:0]     ex_store_data,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   output logic                      ex_rd_we,
   output logic                      ex_is_load
);

   id_ex_t ex_q;
   id_ex_t ex_d;
   id_ex_t id_fields;
   logic   valid_q;
   logic   valid_d;
   logic   hazard;
   data_t  fwd_rs1;
   data_t  fwd_rs2;

   assign id_fields = '{
      rs1_addr: id_rs1_addr,
      rs1_used: id_rs1_used,
      rs1_data: id_rs1_data,
      rs2_addr: id_rs2_addr,
      rs2_used: id_rs2_used,
      rs2_data: id_rs2_data,
      imm:      id_imm,
      pc:       id_pc,
      use_pc:   id_use_pc,
      use_imm:  id_use_imm,
      sub:      id_sub,
      rd_addr:  id_rd_addr,
      rd_we:    id_rd_we,
      is_load:  id_is_load
   };

   // Bubbles drive no write and no load, so they can neither forward nor raise a hazard.
   assign ex_valid   = valid_q;
   assign ex_rd_addr = ex_q.rd_addr;
   assign ex_rd_we   = ex_q.rd_we & valid_q;
   assign ex_is_load = ex_q.is_load & valid_q;

   assign hazard = id_valid & ex_is_load &
                   (src_hit(id_rs1_addr, id_rs1_used, ex_rd_addr, ex_rd_we) |
                    src_hit(id_rs2_addr, id_rs2_used, ex_rd_addr, ex_rd_we));

   assign stall_id = hazard & ~flush;

   always_comb begin
      ex_d    = ex_q;
      valid_d = 1'b0;
      if (!flush && !hazard) begin
         ex_d    = id_fields;
         valid_d = id_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ex_q    <= ex_d;
         valid_q <= valid_d;
      end
   end

   iex_fwd_mux u_fwd_rs1 (
      .idx_i         (ex_q.rs1_addr),
      .used_i        (ex_q.rs1_used),
      .reg_data_i    (ex_q.rs1_data),
      .exm_rd_addr_i (exm_rd_addr),
      .exm_rd_we_i   (exm_rd_we),
      .exm_is_load_i (exm_is_load),
      .exm_data_i    (exm_data),
      .mwb_rd_addr_i (mwb_rd_addr),
      .mwb_rd_we_i   (mwb_rd_we),
      .mwb_data_i    (mwb_data),
      .data_o        (fwd_rs1)
   );

   iex_fwd_mux u_fwd_rs2 (
      .idx_i         (ex_q.rs2_addr),
      .used_i        (ex_q.rs2_used),
      .reg_data_i    (ex_q.rs2_data),
      .exm_rd_addr_i (exm_rd_addr),
      .exm_rd_we_i   (exm_rd_we),
      .exm_is_load_i (exm_is_load),
      .exm_data_i    (exm_data),
      .mwb_rd_addr_i (mwb_rd_addr),
      .mwb_rd_we_i   (mwb_rd_we),
      .mwb_data_i    (mwb_data),
      .data_o        (fwd_rs2)
   );

   assign adder_data_in_1 = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
   assign adder_data_in_2 = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign ex_store_data   = fwd_rs2;
   assign sub             = ex_q.sub & valid_q;

endmodule
